fetch_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register that feeds the decode-stage controller. Holds the fetch PC and issues in-order requests to a variable-latency instruction memory. Buffers returned instructions and presents one instruction per cycle to decode. Handles hazard-unit stall/flush and execute-stage redirects, using an epoch tag to discard stale responses.

---
 rtl/pipeline_pkg.sv | 21 ++
 rtl/fetch_fifo.sv | 66 ++++++
 rtl/fetch_stage.sv | 174 +++++++++++++++++
 tb/tb_fetch_stage.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared types and constants for the fetch/decode pipeline.
package pipeline_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic            epoch;
    } fetch_tag_t;

    function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
        return pc + XLEN'(4);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with clear; head entry is visible combinationally on pop_data.
module fetch_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [31:0]
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  T                             push_data,
    input  logic                         pop,
    input  logic                         clear,
    output T                             pop_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    T               mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic [CW-1:0]  cnt;
    logic           do_push;
    logic           do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign empty    = (cnt == '0);
    assign full     = (cnt == CW'(DEPTH));
    assign count    = cnt;
    assign pop_data = mem[rd_ptr];
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push)
                wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)
                rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch with epoch-tagged in-order requests, instruction buffer and IF/ID register.
// Optional FETCH_PERF_EN builds the bubble/drop performance counters.
module fetch_stage
    import pipeline_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter int              BUF_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            StallF,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    output logic [XLEN-1:0] InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD,
    output logic [31:0]     perf_bubble_cnt,
    output logic [31:0]     perf_drop_cnt
);

    localparam int CW = $clog2(BUF_DEPTH + 1);

    logic            run;
    logic            epoch;
    logic [XLEN-1:0] pcf;

    fetch_tag_t      tag_in;
    fetch_tag_t      tag_head;
    logic            tag_full;
    logic            tag_empty;
    logic [CW-1:0]   tag_cnt;

    fetch_entry_t    buf_in;
    fetch_entry_t    buf_head;
    logic            buf_full;
    logic            buf_empty;
    logic [CW-1:0]   buf_cnt;

    logic [CW:0]     credits_used;
    logic            req_fire;
    logic            rsp_keep;
    logic            if_load;
    logic            bypass;
    logic            buf_push;
    logic            buf_pop;

    // In-flight plus buffered never exceeds BUF_DEPTH, so the buffer cannot overflow.
    assign credits_used   = {1'b0, tag_cnt} + {1'b0, buf_cnt};
    assign imem_req_valid = run & ~StallF & ~PCSrcE & (credits_used < (CW+1)'(BUF_DEPTH));
    assign imem_req_addr  = pcf;
    assign req_fire       = imem_req_valid & imem_req_ready;

    // A response in the redirect cycle belongs to the old epoch and is discarded.
    assign rsp_keep = imem_rsp_valid & (tag_head.epoch == epoch) & ~PCSrcE;
    assign if_load  = ~FlushD & ~StallD;
    assign bypass   = rsp_keep & buf_empty & if_load;
    assign buf_push = rsp_keep & ~bypass;
    assign buf_pop  = if_load & ~buf_empty;

    assign tag_in = '{pc: pcf, epoch: epoch};
    assign buf_in = '{pc: tag_head.pc, instr: imem_rsp_data};

    fetch_fifo #(.DEPTH(BUF_DEPTH), .T(fetch_tag_t)) u_tag_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (req_fire),
        .push_data (tag_in),
        .pop       (imem_rsp_valid),
        .clear     (1'b0),
        .pop_data  (tag_head),
        .full      (tag_full),
        .empty     (tag_empty),
        .count     (tag_cnt)
    );

    fetch_fifo #(.DEPTH(BUF_DEPTH), .T(fetch_entry_t)) u_instr_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (buf_push),
        .push_data (buf_in),
        .pop       (buf_pop),
        .clear     (PCSrcE),
        .pop_data  (buf_head),
        .full      (buf_full),
        .empty     (buf_empty),
        .count     (buf_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run   <= 1'b0;
            epoch <= 1'b0;
            pcf   <= RESET_PC;
        end else begin
            run <= 1'b1;
            if (PCSrcE) begin
                pcf   <= PCTargetE;
                epoch <= ~epoch;
            end else if (req_fire) begin
                pcf <= pc_plus4(pcf);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            InstrD   <= NOP_INSTR;
            PCD      <= '0;
            PCPlus4D <= '0;
            ValidD   <= 1'b0;
        end else if (FlushD) begin
            InstrD   <= NOP_INSTR;
            PCD      <= '0;
            PCPlus4D <= '0;
            ValidD   <= 1'b0;
        end else if (!StallD) begin
            if (!buf_empty) begin
                InstrD   <= buf_head.instr;
                PCD      <= buf_head.pc;
                PCPlus4D <= pc_plus4(buf_head.pc);
                ValidD   <= 1'b1;
            end else if (bypass) begin
                InstrD   <= buf_in.instr;
                PCD      <= buf_in.pc;
                PCPlus4D <= pc_plus4(buf_in.pc);
                ValidD   <= 1'b1;
            end else begin
                InstrD   <= NOP_INSTR;
                PCD      <= '0;
                PCPlus4D <= '0;
                ValidD   <= 1'b0;
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic bubble_evt;
    logic drop_evt;

    assign bubble_evt = if_load & buf_empty & ~bypass;
    assign drop_evt   = imem_rsp_valid & ~rsp_keep;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_bubble_cnt <= '0;
            perf_drop_cnt   <= '0;
        end else begin
            if (bubble_evt)
                perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
            if (drop_evt)
                perf_drop_cnt <= perf_drop_cnt + 32'd1;
        end
    end
`else
    assign perf_bubble_cnt = '0;
    assign perf_drop_cnt   = '0;
`endif

    a_rsp_has_tag: assert property (@(posedge clk) disable iff (!rst_n)
        imem_rsp_valid |-> !tag_empty);
    a_tag_no_ovf: assert property (@(posedge clk) disable iff (!rst_n)
        !(req_fire && tag_full));
    a_buf_no_ovf: assert property (@(posedge clk) disable iff (!rst_n)
        !(buf_push && buf_full));

endmodule

// File: tb/tb_fetch_stage.sv
// Directed and randomized bench for fetch_stage against a queue-based fetch model.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        StallF, StallD, FlushD, PCSrcE;
    logic [31:0] PCTargetE;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        ValidD;
    logic [31:0] perf_bubble_cnt, perf_drop_cnt;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(RST_PC), .BUF_DEPTH(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .StallF          (StallF),
        .StallD          (StallD),
        .FlushD          (FlushD),
        .PCSrcE          (PCSrcE),
        .PCTargetE       (PCTargetE),
        .InstrD          (InstrD),
        .PCD             (PCD),
        .PCPlus4D        (PCPlus4D),
        .ValidD          (ValidD),
        .perf_bubble_cnt (perf_bubble_cnt),
        .perf_drop_cnt   (perf_drop_cnt)
    );

    // Outstanding requests (memory side and staleness) and instructions fetched but not yet decoded.
    typedef struct { logic [31:0] pc; logic [31:0] data; int due; bit stale; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

    req_t        inq[$];
    ent_t        avail[$];
    bit          run_m;
    logic [31:0] pcf_m, pc_m, instr_m;
    bit          valid_m;
    int unsigned bub_m, drop_m;
    int          cyc;
    int          lat_min, lat_max;
    logic [31:0] key;
    int          nvec = 0;
    int          nmis = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_ifid();
        chk("ValidD", 32'(ValidD), 32'(valid_m));
        chk("InstrD", InstrD, valid_m ? instr_m : NOP);
        if (valid_m) begin
            chk("PCD", PCD, pc_m);
            chk("PCPlus4D", PCPlus4D, pc_m + 32'd4);
        end
`ifdef FETCH_PERF_EN
        chk("perf_bubble", perf_bubble_cnt, bub_m);
        chk("perf_drop", perf_drop_cnt, drop_m);
`else
        chk("perf_bubble_tied", perf_bubble_cnt, 32'd0);
        chk("perf_drop_tied", perf_drop_cnt, 32'd0);
`endif
    endtask

    function automatic bit no_stale();
        foreach (inq[i]) if (inq[i].stale) return 1'b0;
        return 1'b1;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 0; PCTargetE = '0;
        imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = '0;
        inq.delete(); avail.delete();
        run_m = 0; pcf_m = RST_PC; pc_m = '0; instr_m = NOP; valid_m = 0;
        bub_m = 0; drop_m = 0; cyc = 0;
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_req_addr", imem_req_addr, RST_PC);
        chk("rst_PCD", PCD, 32'd0);
        chk("rst_PCPlus4D", PCPlus4D, 32'd0);
        check_ifid();
        @(posedge clk); #2;
        rst_n = 1'b1;
    endtask

    task automatic step(input bit sf, input bit sd, input bit fd, input bit redir,
                        input logic [31:0] tgt, input bit rdy);
        bit   rv, exp_req, fire, got;
        ent_t g, h;
        req_t e;
        int   lat;
        @(negedge clk);
        rv = (inq.size() > 0) && (inq[0].due <= cyc);
        StallF = sf; StallD = sd; FlushD = fd; PCSrcE = redir; PCTargetE = tgt;
        imem_req_ready = rdy;
        imem_rsp_valid = rv;
        imem_rsp_data  = rv ? inq[0].data : 32'hDEAD_BEEF;
        #1;
        exp_req = run_m && !sf && !redir && (inq.size() + avail.size() < 4);
        chk("req_valid", 32'(imem_req_valid), 32'(exp_req));
        chk("req_addr", imem_req_addr, pcf_m);
        fire = exp_req && rdy;
        got = 0;
        if (rv) begin
            e = inq.pop_front();
            if (e.stale || redir) drop_m++;
            else begin got = 1; g.pc = e.pc; g.instr = e.data; end
        end
        if (fd) begin
            valid_m = 0;
        end else if (!sd) begin
            if (avail.size() > 0) begin
                h = avail.pop_front();
                valid_m = 1; pc_m = h.pc; instr_m = h.instr;
            end else if (got) begin
                valid_m = 1; pc_m = g.pc; instr_m = g.instr; got = 0;
            end else begin
                valid_m = 0; bub_m++;
            end
        end
        if (got) avail.push_back(g);
        if (fire) begin
            lat = $urandom_range(lat_max, lat_min);
            inq.push_back('{pcf_m, pcf_m ^ key, cyc + lat, 1'b0});
        end
        if (redir) begin
            avail.delete();
            foreach (inq[i]) inq[i].stale = 1'b1;
            pcf_m = tgt;
        end else if (fire) begin
            pcf_m = pcf_m + 32'd4;
        end
        run_m = 1;
        cyc++;
        @(posedge clk); #1;
        check_ifid();
    endtask

    task automatic run_normal(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, '0, 1);
    endtask

    initial begin
        int unsigned b0;
        bit          rd;
        logic [31:0] t;
        lat_min = 1; lat_max = 1; key = '0;
        StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 0; PCTargetE = '0;
        imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = '0;

        do_reset();
        run_normal(12);

        // Redirect with requests still outstanding in a slow memory.
        lat_min = 3; lat_max = 3;
        run_normal(3);
        step(0, 0, 1, 1, 32'h0000_0100, 1);
        lat_min = 1; lat_max = 1;
        run_normal(8);

        // Decode stall, then flush+stall together, then fetch stall.
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, '0, 1);
        run_normal(6);
        step(0, 1, 1, 0, '0, 1);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, '0, 1);
        run_normal(4);

        // Drain, then memory refuses requests for 5 cycles.
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0, '0, 1);
        b0 = bub_m;
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, '0, 0);
`ifdef FETCH_PERF_EN
        chk("bubble_delta_5", perf_bubble_cnt - b0, 32'd5);
`endif
        run_normal(3);

        // PC wrap at the top of the address space.
        step(0, 0, 1, 1, 32'hFFFF_FFFC, 1);
        step(0, 0, 0, 0, '0, 1);
        chk("wrap_addr", imem_req_addr, 32'h0000_0000);
        run_normal(6);

        // Randomized traffic with variable latency.
        lat_min = 1; lat_max = 4; key = $urandom();
        for (int i = 0; i < 1500; i++) begin
            rd = ($urandom_range(31) == 0) && no_stale();
            t  = $urandom() & 32'hFFFF_FFFC;
            step($urandom_range(7) == 0, $urandom_range(5) == 0,
                 ($urandom_range(9) == 0) || rd, rd, t, $urandom_range(3) != 0);
        end

        // Reset in the middle of traffic.
        lat_min = 3; lat_max = 3;
        run_normal(2);
        do_reset();
        lat_min = 1; lat_max = 1; key = '0;
        run_normal(10);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
